// File: rtl/arp_rx.sv
// arp_rx: GMII receive-side ARP frame parser.
//   Strips the preamble/SFD, runs a CRC32 over dest..FCS, captures the ARP
//   fields by byte index and, one clock after the frame-evaluation cycle,
//   pulses arp_valid for accepted ARP request/reply packets.
// Ports:
//   clock      GMII RX clock (125 MHz)
//   reset_n    synchronous active-low reset
//   rx_dv      GMII receive data valid
//   rx_er      GMII receive error
//   rx_data    GMII receive byte
//   arp_valid  1-cycle pulse per accepted ARP packet
//   arp_op     ARP opcode, held until next pulse
//   arp_sha    sender hardware address, held until next pulse
//   arp_spa    sender protocol address, held until next pulse
//   arp_bcast  frame destination was the broadcast MAC
//   good_cnt   accepted ARP packets (saturating)
//   err_cnt    frames rejected for FCS/length/rx_er/SFD error (saturating)
module arp_rx #(
  parameter logic [47:0] MY_MAC  = 48'h00301ba0a48e,
  parameter logic [31:0] MY_IP   = 32'h0a00150a,
  parameter int          MAX_LEN = 1518
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rx_data,
  output logic        arp_valid,
  output logic [15:0] arp_op,
  output logic [47:0] arp_sha,
  output logic [31:0] arp_spa,
  output logic        arp_bcast,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt
);

  localparam int              IDX_W   = $clog2(MAX_LEN + 2);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_LEN);
  localparam logic [IDX_W-1:0] IDX_SAT = IDX_W'(MAX_LEN + 1);
  localparam logic [IDX_W-1:0] IDX_MIN = IDX_W'(64);
  localparam logic [31:0]     POLY    = 32'hEDB88320;
  localparam logic [31:0]     RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {IDLE, PRE, DATA, DROP, CHECK} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       crc_q;

  logic [47:0] dest_q, sha_q;
  logic [15:0] etype_q, htype_q, ptype_q, oper_q;
  logic [7:0]  hlen_q, plen_q;
  logic [31:0] spa_q, tpa_q;

  logic       crc_clr, byte_en, start_err, data_err, frame_bad, vld_p0;
  logic       is_pre, is_sfd, fcs_ok, dest_ok, hdr_ok, bcast;
  logic [1:0] err_add;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic in_rng(input logic [IDX_W-1:0] i, input int lo, input int hi);
    return (int'(i) >= lo) && (int'(i) <= hi);
  endfunction

  assign is_pre = (rx_data == 8'h55);
  assign is_sfd = (rx_data == 8'hD5);

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; CHECK lasts one cycle and reacts to rx_dv like IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, CHECK: begin
        if (!rx_dv)      state_d = IDLE;
        else if (is_pre) state_d = PRE;
        else if (is_sfd) state_d = DATA;
        else             state_d = DROP;
      end
      PRE: begin
        if (!rx_dv)              state_d = IDLE;
        else if (rx_er)          state_d = DROP;
        else if (is_pre)         state_d = PRE;
        else if (is_sfd)         state_d = DATA;
        else                     state_d = DROP;
      end
      DATA: begin
        if (!rx_dv)                        state_d = CHECK;
        else if (rx_er || idx_q == IDX_MAX) state_d = DROP;
      end
      DROP:    if (!rx_dv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: datapath strobes and frame verdict
  always_comb begin
    crc_clr   = (state_q == IDLE) || (state_q == CHECK);
    byte_en   = (state_q == DATA) && rx_dv;
    start_err = (crc_clr && rx_dv && !is_pre && !is_sfd) ||
                ((state_q == PRE) && rx_dv && (rx_er || (!is_pre && !is_sfd)));
    data_err  = byte_en && (rx_er || idx_q == IDX_MAX);
    fcs_ok    = (crc_q == RESIDUE) && (idx_q >= IDX_MIN);
    bcast     = (dest_q == 48'hFFFF_FFFF_FFFF);
    dest_ok   = bcast || (dest_q == MY_MAC);
    hdr_ok    = (etype_q == 16'h0806) && (htype_q == 16'h0001) &&
                (ptype_q == 16'h0800) && (hlen_q == 8'h06) && (plen_q == 8'h04) &&
                ((oper_q == 16'd1) || (oper_q == 16'd2)) && (tpa_q == MY_IP);
    frame_bad = (state_q == CHECK) && !fcs_ok;
    vld_p0    = (state_q == CHECK) && fcs_ok && dest_ok && hdr_ok;
    err_add   = {1'b0, start_err} + {1'b0, data_err} + {1'b0, frame_bad};
  end

  // Stage p0: byte index and CRC accumulation
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      idx_q <= '0;
      crc_q <= 32'hFFFF_FFFF;
    end else if (crc_clr) begin
      idx_q <= '0;
      crc_q <= 32'hFFFF_FFFF;
    end else if (byte_en) begin
      crc_q <= crc_byte(crc_q, rx_data);
      if (idx_q != IDX_SAT) idx_q <= idx_q + 1'b1;
    end
  end

  // Stage p0: field capture, big-endian shift-in by byte index
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dest_q  <= '0;
      etype_q <= '0;
      htype_q <= '0;
      ptype_q <= '0;
      hlen_q  <= '0;
      plen_q  <= '0;
      oper_q  <= '0;
      sha_q   <= '0;
      spa_q   <= '0;
      tpa_q   <= '0;
    end else if (byte_en) begin
      if (in_rng(idx_q, 0, 5))   dest_q  <= {dest_q[39:0], rx_data};
      if (in_rng(idx_q, 12, 13)) etype_q <= {etype_q[7:0], rx_data};
      if (in_rng(idx_q, 14, 15)) htype_q <= {htype_q[7:0], rx_data};
      if (in_rng(idx_q, 16, 17)) ptype_q <= {ptype_q[7:0], rx_data};
      if (in_rng(idx_q, 18, 18)) hlen_q  <= rx_data;
      if (in_rng(idx_q, 19, 19)) plen_q  <= rx_data;
      if (in_rng(idx_q, 20, 21)) oper_q  <= {oper_q[7:0], rx_data};
      if (in_rng(idx_q, 22, 27)) sha_q   <= {sha_q[39:0], rx_data};
      if (in_rng(idx_q, 28, 31)) spa_q   <= {spa_q[23:0], rx_data};
      if (in_rng(idx_q, 38, 41)) tpa_q   <= {tpa_q[23:0], rx_data};
    end
  end

  // Stage p1: registered report and counters
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      arp_valid <= 1'b0;
      arp_op    <= '0;
      arp_sha   <= '0;
      arp_spa   <= '0;
      arp_bcast <= 1'b0;
      good_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      arp_valid <= vld_p0;
      if (vld_p0) begin
        arp_op    <= oper_q;
        arp_sha   <= sha_q;
        arp_spa   <= spa_q;
        arp_bcast <= bcast;
        good_cnt  <= sat_add(good_cnt, 2'd1);
      end
      err_cnt <= sat_add(err_cnt, err_add);
    end
  end

endmodule

// File: tb/tb_arp_rx.sv
// tb_arp_rx: directed-frame bench for arp_rx with a scoreboard queue of
// expected ARP reports, popped by an independent output monitor.
module tb_arp_rx;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        arp_valid;
  logic [15:0] arp_op;
  logic [47:0] arp_sha;
  logic [31:0] arp_spa;
  logic        arp_bcast;
  logic [15:0] good_cnt;
  logic [15:0] err_cnt;

  arp_rx dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx_dv     (rx_dv),
    .rx_er     (rx_er),
    .rx_data   (rx_data),
    .arp_valid (arp_valid),
    .arp_op    (arp_op),
    .arp_sha   (arp_sha),
    .arp_spa   (arp_spa),
    .arp_bcast (arp_bcast),
    .good_cnt  (good_cnt),
    .err_cnt   (err_cnt)
  );

  always #4 clock = ~clock;

  typedef struct {
    logic [15:0] op;
    logic [47:0] sha;
    logic [31:0] spa;
    logic        bcast;
    logic [15:0] good;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] frm[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MY_MAC = 48'h00301ba0a48e;
  localparam logic [31:0] MY_IP  = 32'h0a00150a;
  localparam logic [47:0] SHA1   = 48'h001122334455;
  localparam logic [31:0] SPA1   = 32'h0A001563;
  localparam logic [47:0] SHA2   = 48'h0a0b0c0d0e0f;
  localparam logic [31:0] SPA2   = 32'h0A000101;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every arp_valid sample consumes one scoreboard entry
  always @(negedge clock) begin : mon
    exp_t e;
    if (arp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got arp_valid=1 op=%0h expected no pulse", arp_op);
      end else begin
        e = sb.pop_front();
        check("arp_op",    64'(arp_op),    64'(e.op));
        check("arp_sha",   64'(arp_sha),   64'(e.sha));
        check("arp_spa",   64'(arp_spa),   64'(e.spa));
        check("arp_bcast", 64'(arp_bcast), 64'(e.bcast));
        check("good_cnt_at_pulse", 64'(good_cnt), 64'(e.good));
      end
    end
  end

  task automatic push_be(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endtask

  // Builds dest..FCS; n_data bytes before the 4-byte FCS
  task automatic build_frame(input logic [47:0] dest, input logic [15:0] oper,
                             input logic [47:0] sha, input logic [31:0] spa,
                             input logic [31:0] tpa, input int n_data, input bit bad_fcs);
    logic [31:0] crc;
    logic        fb;
    frm.delete();
    push_be(dest, 6);
    push_be(48'h020000000001, 6);
    push_be(48'h0806, 2);
    push_be(48'h0001, 2);
    push_be(48'h0800, 2);
    push_be(48'h06, 1);
    push_be(48'h04, 1);
    push_be({32'h0, oper}, 2);
    push_be(sha, 6);
    push_be({16'h0, spa}, 4);
    push_be(48'h0, 6);
    push_be({16'h0, tpa}, 4);
    while (frm.size() < n_data) frm.push_back(8'h00);
    crc = 32'hFFFF_FFFF;
    foreach (frm[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb  = crc[0] ^ frm[k][b];
        crc = crc >> 1;
        if (fb) crc = crc ^ 32'hEDB88320;
      end
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) frm.push_back(crc[8*i +: 8]);
    if (bad_fcs) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'hFF;
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    rx_dv   = dv;
    rx_er   = er;
    rx_data = d;
    @(posedge clock);
    #1;
  endtask

  // 7x55 + D5, frame bytes, then a 12-cycle gap
  task automatic send_frame(input int er_idx, input int rst_idx);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    foreach (frm[i]) begin
      if (i == rst_idx)     reset_n = 1'b0;
      if (i == rst_idx + 2) reset_n = 1'b1;
      drive(1'b1, (i == er_idx), frm[i]);
    end
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic push_exp(input logic [15:0] op, input logic [47:0] sha,
                          input logic [31:0] spa, input logic bc, input logic [15:0] good);
    exp_t e;
    e.op = op; e.sha = sha; e.spa = spa; e.bcast = bc; e.good = good;
    sb.push_back(e);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout expected end of run");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00);
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00);

    check("rst_arp_valid", 64'(arp_valid), 64'd0);
    check("rst_arp_op",    64'(arp_op),    64'd0);
    check("rst_arp_sha",   64'(arp_sha),   64'd0);
    check("rst_arp_spa",   64'(arp_spa),   64'd0);
    check("rst_arp_bcast", 64'(arp_bcast), 64'd0);
    check("rst_good_cnt",  64'(good_cnt),  64'd0);
    check("rst_err_cnt",   64'(err_cnt),   64'd0);

    // Broadcast request
    build_frame(BCAST, 16'd1, SHA1, SPA1, MY_IP, 60, 1'b0);
    push_exp(16'd1, SHA1, SPA1, 1'b1, 16'd1);
    send_frame(-1, -1);
    check("t1_good", 64'(good_cnt), 64'd1);
    check("t1_err",  64'(err_cnt),  64'd0);

    // Corrupted FCS
    build_frame(BCAST, 16'd1, SHA1, SPA1, MY_IP, 60, 1'b1);
    send_frame(-1, -1);
    check("t2_good", 64'(good_cnt), 64'd1);
    check("t2_err",  64'(err_cnt),  64'd1);

    // Unicast reply to us, then unicast to another station
    build_frame(MY_MAC, 16'd2, SHA2, SPA2, MY_IP, 60, 1'b0);
    push_exp(16'd2, SHA2, SPA2, 1'b0, 16'd2);
    send_frame(-1, -1);
    build_frame(SHA1, 16'd1, SHA2, SPA2, MY_IP, 60, 1'b0);
    send_frame(-1, -1);
    check("t3_good",      64'(good_cnt), 64'd2);
    check("t3_err",       64'(err_cnt),  64'd1);
    check("t3_op_held",   64'(arp_op),   64'd2);
    check("t3_sha_held",  64'(arp_sha),  64'(SHA2));

    // rx_er mid-frame, then a good frame after the gap
    build_frame(BCAST, 16'd1, SHA1, SPA1, MY_IP, 60, 1'b0);
    send_frame(30, -1);
    check("t4_err_after_rxer", 64'(err_cnt), 64'd2);
    push_exp(16'd1, SHA1, SPA1, 1'b1, 16'd3);
    send_frame(-1, -1);
    check("t4_good", 64'(good_cnt), 64'd3);
    check("t4_err",  64'(err_cnt),  64'd2);

    // Runt (60 bytes incl. FCS) and oversize (1600 bytes)
    build_frame(BCAST, 16'd1, SHA1, SPA1, MY_IP, 56, 1'b0);
    send_frame(-1, -1);
    check("t5_err_runt", 64'(err_cnt), 64'd3);
    build_frame(BCAST, 16'd1, SHA1, SPA1, MY_IP, 1596, 1'b0);
    send_frame(-1, -1);
    check("t5_good", 64'(good_cnt), 64'd3);
    check("t5_err",  64'(err_cnt),  64'd4);

    // Reset during a valid frame, then a good frame
    build_frame(BCAST, 16'd1, SHA1, SPA1, MY_IP, 60, 1'b0);
    send_frame(-1, 20);
    check("t6_good_after_rst", 64'(good_cnt), 64'd0);
    check("t6_err_after_rst",  64'(err_cnt),  64'd1);
    push_exp(16'd1, SHA1, SPA1, 1'b1, 16'd1);
    send_frame(-1, -1);
    check("t6_good", 64'(good_cnt), 64'd1);
    check("t6_err",  64'(err_cnt),  64'd1);

    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'h00);
    check("sb_pending", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
